// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// button_event_arbiter : shared-timebase debouncer for N buttons, turning
// presses into round-robin arbitrated valid/ready events.   Rev 1.0
// ============================================================================
module button_event_arbiter #(
    parameter int N            = 4,
    parameter int TICK_DIV     = 50_000,
    parameter int STABLE_TICKS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         button_i,
    output logic [N-1:0]         debounced_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [$clog2(N)-1:0] evt_id_o,
    output logic                 dropped_o,
    input  logic                 clr_drop_i
);
    localparam int IDW = $clog2(N);
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

    logic [N-1:0]          sync1_q, sync2_q;
    logic [PW-1:0]         presc_q, presc_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]          deb_q, deb_d;
    logic [N-1:0]          pending_q, pending_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        evt_id_q, evt_id_d;
    logic                  dropped_q, dropped_d;
    state_t                state_q, state_d;

    logic                  w_tick;
    logic [N-1:0]          w_rise;
    logic [N-1:0]          w_clr;
    logic [IDW-1:0]        w_sel;
    logic                  w_any;
    logic                  w_drop;

    assign w_tick  = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = w_tick ? '0 : presc_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (w_tick) begin
                if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lowest offset from ptr wins, so scan from the far end downwards.
    always_comb begin
        w_sel = '0;
        w_any = |pending_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_q[IDW'((int'(ptr_q) + k) % N)]) begin
                w_sel = IDW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        ptr_d    = ptr_q;
        w_clr    = '0;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    evt_id_d = w_sel;
                    w_clr    = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    state_d  = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready_i) begin
                    state_d = S_IDLE;
                    ptr_d   = (evt_id_q == IDW'(N - 1)) ? '0 : evt_id_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new press on a bit being granted this cycle re-queues rather than drops.
    assign w_rise    = deb_d & ~deb_q;
    assign pending_d = (pending_q & ~w_clr) | w_rise;
    assign w_drop    = |(w_rise & pending_q & ~w_clr);
    assign dropped_d = w_drop ? 1'b1 : (clr_drop_i ? 1'b0 : dropped_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            deb_q     <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            evt_id_q  <= '0;
            dropped_q <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            sync1_q   <= button_i;
            sync2_q   <= sync1_q;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            evt_id_q  <= evt_id_d;
            dropped_q <= dropped_d;
            state_q   <= state_d;
        end
    end

    assign debounced_o = deb_q;
    assign evt_valid_o = (state_q == S_OFFER);
    assign evt_id_o    = evt_id_q;
    assign dropped_o   = dropped_q;

endmodule
`default_nettype wire
